// File: rtl/wave_table_loader_if.sv
// Sample-stream, RAM write port and status signals of the wave table loader.
// The loader uses the slave modport. The source/controller side uses master.
interface wave_table_loader_if #(
  parameter int unsigned COUNT_SIZE = 8,
  parameter int unsigned DATA_W     = 8
);
  logic                  start;
  logic                  s_valid;
  logic [DATA_W-1:0]     s_data;
  logic                  s_ready;
  logic                  we;
  logic [COUNT_SIZE-1:0] waddr;
  logic [DATA_W-1:0]     wdata;
  logic                  table_ready;
  logic                  load_err;

  modport master (
    output start, s_valid, s_data,
    input  s_ready, we, waddr, wdata, table_ready, load_err
  );

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, we, waddr, wdata, table_ready, load_err
  );
endinterface

// File: rtl/wave_table_loader.sv
// Fills a 2^COUNT_SIZE-entry waveform RAM from a valid/ready stream and flags the
// table valid once complete. A stalled source causes an abort, and the table is not marked valid.
module wave_table_loader #(
  parameter int unsigned COUNT_SIZE = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TIMEOUT    = 1023
) (
  input logic                 clk,
  input logic                 resetN,
  wave_table_loader_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  // The counter only needs to hold 0..TIMEOUT-1. The abort fires on the idle cycle that reaches TIMEOUT.
  localparam int unsigned      TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TLast   = TW'(TIMEOUT - 1);
  localparam logic [COUNT_SIZE-1:0] LastIdx = {COUNT_SIZE{1'b1}};

  logic [1:0]            state_q, state_d;
  logic [COUNT_SIZE-1:0] idx_q, idx_d;
  logic [COUNT_SIZE-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  we_q, we_d;
  logic                  s_ready_q, s_ready_d;
  logic                  table_ready_q, table_ready_d;
  logic                  load_err_q, load_err_d;
  logic                  xfer;

  assign xfer = bus.s_valid & s_ready_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    tcnt_d        = tcnt_q;
    we_d          = 1'b0;
    s_ready_d     = s_ready_q;
    table_ready_d = table_ready_q;
    load_err_d    = load_err_q;

    // start wins over the handshake. A coinciding sample is dropped.
    if (bus.start) begin
      state_d       = StLoad;
      idx_d         = '0;
      waddr_d       = '0;
      tcnt_d        = '0;
      s_ready_d     = 1'b1;
      table_ready_d = 1'b0;
      load_err_d    = 1'b0;
    end else if (state_q == StLoad) begin
      if (xfer) begin
        we_d    = 1'b1;
        wdata_d = bus.s_data;
        waddr_d = idx_q;
        idx_d   = idx_q + 1'b1;
        tcnt_d  = '0;
        if (idx_q == LastIdx) begin
          state_d       = StDone;
          s_ready_d     = 1'b0;
          table_ready_d = 1'b1;
        end
      end else if (tcnt_q == TLast) begin
        state_d       = StErr;
        tcnt_d        = '0;
        s_ready_d     = 1'b0;
        table_ready_d = 1'b0;
        load_err_d    = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      tcnt_q        <= '0;
      we_q          <= 1'b0;
      s_ready_q     <= 1'b0;
      table_ready_q <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      tcnt_q        <= tcnt_d;
      we_q          <= we_d;
      s_ready_q     <= s_ready_d;
      table_ready_q <= table_ready_d;
      load_err_q    <= load_err_d;
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.we          = we_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.table_ready = table_ready_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: doc/wave_table_loader.md
Name: wave_table_loader

Overview:
- Write-side counterpart to the audio table address counter.
- Fills a 2^COUNT_SIZE-entry waveform RAM from a valid/ready sample stream, at incrementing write addresses from 0 to the last entry.
- Asserts table_ready once the table is complete; table_ready gates the read-side counter enable.
- Provides restart and an inactivity timeout, so a stalled source cannot leave a half-written table marked valid.

Parameters:
- COUNT_SIZE, 8, table address width; table depth is 2^COUNT_SIZE.
- DATA_W, 8, sample width.
- TIMEOUT, 1023, maximum consecutive LOAD cycles with s_valid low before aborting; must be at least 1.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to (re)load the table
- s_valid  in  1  source sample valid
- s_data  in  DATA_W  source sample
- s_ready  out  1  loader accepts a sample this cycle
- we  out  1  RAM write enable
- waddr  out  COUNT_SIZE  RAM write address
- wdata  out  DATA_W  RAM write data
- table_ready  out  1  table complete and valid; drives reader en1
- load_err  out  1  sticky: last load aborted by timeout

Behaviour:
- Reset (asynchronous, resetN low): state=IDLE, waddr=0, we=0, wdata=0, s_ready=0, table_ready=0, load_err=0, timeout counter=0.
- States: IDLE, LOAD, DONE, ERR. All outputs are registered.
- IDLE, DONE, ERR on start=1: next state LOAD; waddr<=0; table_ready<=0; load_err<=0; timeout counter<=0.
- LOAD, s_ready: s_ready=1 in the LOAD state only. It is a registered output, so it is high from the first cycle in LOAD and low from the first cycle after leaving LOAD.
- LOAD, transfer (s_valid & s_ready):
  - Next cycle: we=1, wdata=s_data, waddr=address of this sample.
  - Write latency is 1 cycle; one sample is accepted per cycle, back-to-back.
  - The internal write index increments by 1 per transfer.
  - The timeout counter clears on every transfer.
- LOAD, last entry: the transfer of index 2^COUNT_SIZE-1 moves the state to DONE.
  - The final write (we=1) appears in the first DONE cycle.
  - table_ready=1 from that same cycle; the RAM write lands at that clock edge.
  - The index wraps to 0; there is no partial-overflow write.
- LOAD, no transfer: s_valid=0 increments the timeout counter. When the counter reaches TIMEOUT, next state is ERR with load_err=1, table_ready=0, s_ready=0.
- Outside a transfer's following cycle, we=0.
- DONE: holds table_ready=1 and s_ready=0. s_valid is ignored.
- ERR: holds load_err=1 and table_ready=0 until start.
- start during LOAD: restarts immediately.
  - waddr/index reset to 0; timeout counter cleared.
  - A transfer coinciding with start is discarded: no write, and the index is not advanced. start has priority over the handshake.
  - s_ready stays 1.
- Reset mid-LOAD: every output returns to its reset value asynchronously. The table is not valid until a full reload completes.

Test Plan:
- COUNT_SIZE=3, DATA_W=8: start, then 8 back-to-back samples 0x10..0x17 with s_valid=1 -> writes 0x10..0x17 to waddr 0..7, one per cycle; table_ready=1 exactly in the cycle of the waddr=7 write; s_ready=0 afterwards.
- Same config, s_valid toggling 1,0,1,0 -> only valid cycles write; addresses are contiguous 0..7; table_ready is never asserted early.
- TIMEOUT=4: start, 3 samples, then s_valid=0 -> ERR after 4 idle cycles; load_err=1, table_ready=0, s_ready=0, no further we.
- start asserted together with the 5th sample -> that sample is not written; the next accepted sample is written at waddr=0; completion requires 8 fresh samples.
- DONE then start -> table_ready drops in the next cycle and load_err clears; a reload completes normally.
- resetN pulsed low mid-LOAD at waddr=5 -> all outputs are 0 immediately; after release, state is IDLE and no writes occur until start.
